// File: rtl/sprite_mover.sv
// Player-sprite engine: clears the screen, draws a ROM sprite and moves it
// horizontally with erase/redraw, emitting one plotted pixel per cycle.
module sprite_mover #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int SPRITE_W = 11,
    parameter int SPRITE_H = 10,
    parameter int X_START  = 73,
    parameter int Y_START  = 105,
    parameter int STEP     = 5,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = SCREEN_W - SPRITE_W,
    parameter int CW       = 3,
    localparam int AW      = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          left,
    input  logic          right,
    output logic [AW-1:0] rom_addr,
    input  logic [CW-1:0] rom_data,
    output logic [7:0]    x,
    output logic [6:0]    y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic [7:0]    pos_x,
    output logic          done,
    output logic          blocked
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] DRAW  = 3'd2;
    localparam logic [2:0] READY = 3'd3;
    localparam logic [2:0] ERASE = 3'd4;

    localparam logic [7:0] CLR_XL = 8'(SCREEN_W - 1);
    localparam logic [6:0] CLR_YL = 7'(SCREEN_H - 1);
    localparam logic [7:0] SPR_XL = 8'(SPRITE_W - 1);
    localparam logic [6:0] SPR_YL = 7'(SPRITE_H - 1);
    localparam logic [6:0] Y0     = 7'(Y_START);
    localparam logic [7:0] HOME   = 8'(X_START);
    localparam logic [8:0] LO     = 9'(X_MIN);
    localparam logic [8:0] HI     = 9'(X_MAX);
    localparam logic [8:0] STP    = 9'(STEP);

    logic [2:0]    state;
    logic [7:0]    col;
    logic [6:0]    row;
    logic [AW-1:0] idx;
    logic [7:0]    target;
    logic          draw_q;

    logic          issue;
    logic          in_clear;
    logic [7:0]    x_last;
    logic [6:0]    y_last;
    logic          col_end;
    logic          last;
    logic [8:0]    px9;
    logic [8:0]    left_t;
    logic [8:0]    right_t;
    logic [7:0]    move_t;

    assign in_clear = (state == CLEAR);
    assign issue    = in_clear || (state == DRAW) || (state == ERASE);
    assign busy     = issue;
    assign x_last   = in_clear ? CLR_XL : SPR_XL;
    assign y_last   = in_clear ? CLR_YL : SPR_YL;
    assign col_end  = (col == x_last);
    assign last     = col_end && (row == y_last);
    assign rom_addr = idx;

    // Colour is taken straight from the ROM one cycle after the address,
    // aligned with the registered x/y of the same pixel.
    assign colour   = draw_q ? rom_data : '0;

    // Clamped targets in 9 bits so neither direction can wrap.
    assign px9      = {1'b0, pos_x};
    assign left_t   = (px9 < LO + STP) ? LO : px9 - STP;
    assign right_t  = (px9 + STP > HI) ? HI : px9 + STP;
    assign move_t   = left ? left_t[7:0] : right_t[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            col     <= '0;
            row     <= '0;
            idx     <= '0;
            target  <= HOME;
            pos_x   <= HOME;
            x       <= '0;
            y       <= '0;
            plot    <= 1'b0;
            draw_q  <= 1'b0;
            done    <= 1'b0;
            blocked <= 1'b0;
        end else begin
            plot    <= issue;
            draw_q  <= (state == DRAW);
            done    <= (state == DRAW) && last;
            blocked <= 1'b0;

            if (issue) begin
                x <= in_clear ? col : pos_x + col;
                y <= in_clear ? row : Y0 + row;
                if (col_end) begin
                    col <= '0;
                    row <= (row == y_last) ? '0 : row + 7'd1;
                end else begin
                    col <= col + 8'd1;
                end
                idx <= (in_clear || last) ? '0 : idx + AW'(1);
            end

            case (state)
                IDLE: begin
                    if (start) state <= CLEAR;
                end
                CLEAR: begin
                    if (last) state <= DRAW;
                end
                DRAW: begin
                    if (last) state <= READY;
                end
                READY: begin
                    if (left ^ right) begin
                        if (move_t == pos_x) begin
                            blocked <= 1'b1;
                        end else begin
                            target <= move_t;
                            state  <= ERASE;
                        end
                    end
                end
                ERASE: begin
                    if (last) begin
                        pos_x <= target;
                        state <= DRAW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: reference model queues expected plots,
// a negedge monitor pops and compares each plotted pixel.
module tb_sprite_mover;

    localparam int SW   = 160;
    localparam int SH   = 120;
    localparam int PW   = 11;
    localparam int PH   = 10;
    localparam int XS   = 73;
    localparam int YS   = 105;
    localparam int STEP = 5;
    localparam int XMIN = 0;
    localparam int XMAX = 149;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic [6:0] rom_addr;
    logic [2:0] rom_data = 3'd0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic [7:0] pos_x;
    logic       done;
    logic       blocked;

    sprite_mover dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .left     (left),
        .right    (right),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .pos_x    (pos_x),
        .done     (done),
        .blocked  (blocked)
    );

    always #5 clk = ~clk;

    // Synchronous sprite ROM whose content is address mod 8.
    always @(posedge clk) rom_data <= 3'(int'(rom_addr) % 8);

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       d;
    } px_t;

    px_t sb[$];
    px_t e;
    int  checks = 0;
    int  errors = 0;
    int  popped = 0;
    int  blocked_cnt = 0;
    int  mpos = XS;

    always @(negedge clk) begin
        if (blocked) blocked_cnt++;
        if (plot) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_plot x=%0d y=%0d c=%0d, expected no plot",
                         x, y, colour);
            end else begin
                e = sb.pop_front();
                popped++;
                if ({x, y, colour, done} !== e) begin
                    errors++;
                    $display("FAIL plot#%0d got x=%0d y=%0d c=%0d done=%0b, expected x=%0d y=%0d c=%0d done=%0b",
                             popped, x, y, colour, done, e.x, e.y, e.c, e.d);
                end
            end
        end else if (done) begin
            checks++;
            errors++;
            $display("FAIL done_without_plot got done=1, expected 0");
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int tgt(input int p, input bit l);
        if (l) return (p < XMIN + STEP) ? XMIN : p - STEP;
        return (p > XMAX - STEP) ? XMAX : p + STEP;
    endfunction

    task automatic push_clear();
        px_t p;
        for (int yy = 0; yy < SH; yy++)
            for (int xx = 0; xx < SW; xx++) begin
                p.x = 8'(xx);
                p.y = 7'(yy);
                p.c = 3'd0;
                p.d = 1'b0;
                sb.push_back(p);
            end
    endtask

    task automatic push_sprite(input int px, input bit erase);
        px_t p;
        for (int r = 0; r < PH; r++)
            for (int c = 0; c < PW; c++) begin
                p.x = 8'(px + c);
                p.y = 7'(YS + r);
                p.c = erase ? 3'd0 : 3'((r * PW + c) % 8);
                p.d = !erase && (r == PH - 1) && (c == PW - 1);
                sb.push_back(p);
            end
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic after_draw(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_pos"}, int'(pos_x), mpos);
        @(posedge clk);
        #1;
        chk({name, "_queue"}, sb.size(), 0);
    endtask

    task automatic pulse(input bit l, input bit r);
        @(posedge clk);
        #1;
        left  = l;
        right = r;
        @(posedge clk);
        #1;
        left  = 1'b0;
        right = 1'b0;
    endtask

    task automatic do_start();
        push_clear();
        push_sprite(mpos, 1'b0);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(20000, "start_done");
        after_draw("start");
    endtask

    task automatic do_move(input bit l, input bit r);
        int b0;
        int t;
        b0 = blocked_cnt;
        if (l && r) begin
            @(posedge clk);
            #1;
            left  = 1'b1;
            right = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            left  = 1'b0;
            right = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("both_blocked", blocked_cnt, b0);
            chk("both_pos", int'(pos_x), mpos);
        end else begin
            t = tgt(mpos, l);
            if (t == mpos) begin
                pulse(l, r);
                repeat (3) @(posedge clk);
                #1;
                chk("clamp_blocked", blocked_cnt, b0 + 1);
                chk("clamp_pos", int'(pos_x), mpos);
            end else begin
                push_sprite(mpos, 1'b1);
                push_sprite(t, 1'b0);
                mpos = t;
                pulse(l, r);
                wait_done(400, "move_done");
                after_draw("move");
            end
        end
    endtask

    initial begin
        int base;
        int p;
        bit ok;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_blocked", int'(blocked), 0);
        chk("rst_pos", int'(pos_x), XS);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_addr", int'(rom_addr), 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);

        do_start();

        // Reset in the middle of the redraw after a move to 68.
        push_sprite(mpos, 1'b1);
        push_sprite(tgt(mpos, 1'b1), 1'b0);
        base = popped;
        pulse(1'b1, 1'b0);
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(posedge clk);
            #1;
            ok = (popped >= base + 160);
        end
        chk("mid_draw_reached", int'(ok), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        mpos = XS;
        chk("mid_rst_plot", int'(plot), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_pos", int'(pos_x), XS);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_idle", int'(busy), 0);

        do_start();

        // start must be ignored outside IDLE.
        pulse(1'b0, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("start_ignored", int'(busy), 0);

        do_move(1'b1, 1'b0);
        do_move(1'b1, 1'b1);

        // Held left: three back-to-back moves.
        p = mpos;
        for (int k = 0; k < 3; k++) begin
            push_sprite(p, 1'b1);
            push_sprite(tgt(p, 1'b1), 1'b0);
            p = tgt(p, 1'b1);
        end
        mpos = p;
        @(posedge clk);
        #1 left = 1'b1;
        for (int k = 0; k < 3; k++) wait_done(400, "hold_done");
        left = 1'b0;
        after_draw("hold");

        while (mpos > XMIN) do_move(1'b1, 1'b0);
        chk("left_edge", int'(pos_x), XMIN);
        do_move(1'b1, 1'b0);
        while (mpos < XMAX) do_move(1'b0, 1'b1);
        chk("right_edge", int'(pos_x), XMAX);
        do_move(1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4) do_move(1'b1, 1'b0);
            else if (r < 8) do_move(1'b0, 1'b1);
            else do_move(1'b1, 1'b1);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("final_queue", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_mover.md
# sprite_mover

Parametrised player-sprite engine for the space-invaders VGA path: clears the framebuffer, draws a sprite from a ROM, then erases and redraws it at a clamped new X position on left/right commands. It produces a one-pixel-per-cycle plot stream for the VGA adapter. It generalises the fixed 11x10 rocket with:

- configurable sprite size, step and bounds
- edge clamping
- simultaneous-command rejection
- a pipelined 1-cycle-latency ROM interface

## Interface
Parameters:
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- SPRITE_W, 11, sprite width
- SPRITE_H, 10, sprite height
- X_START, 73, home X (sprite left column)
- Y_START, 105, fixed sprite top row
- STEP, 5, pixels moved per command
- X_MIN, 0, leftmost legal X
- X_MAX, SCREEN_W-SPRITE_W (149), rightmost legal X
- CW, 3, colour width

Ports (AW = clog2(SPRITE_W*SPRITE_H)):
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  leave IDLE and begin screen clear
- left  in  1  move-left request, level
- right  in  1  move-right request, level
- rom_addr  out  AW  sprite ROM address, row*SPRITE_W+col
- rom_data  in  CW  ROM colour, valid 1 cycle after rom_addr
- x  out  8  plot X
- y  out  7  plot Y
- colour  out  CW  plot colour
- plot  out  1  pixel write strobe
- busy  out  1  high in CLEAR, ERASE, DRAW
- pos_x  out  8  current sprite X
- done  out  1  1-cycle pulse on the last DRAW pixel's plot
- blocked  out  1  1-cycle pulse when an accepted move is clamped to no change

## Operation
- States: IDLE, CLEAR, DRAW, READY, ERASE.
- IDLE: start=1 -> CLEAR.
- CLEAR:
  - Issue all SCREEN_W*SCREEN_H pixels with colour 0, raster order (x fastest).
  - After the last issue -> DRAW at pos_x.
- DRAW:
  - Issue SPRITE_W*SPRITE_H pixels at (pos_x+col, Y_START+row).
  - rom_addr = row*SPRITE_W+col; colour = rom_data.
  - After the last issue -> READY.
- READY (requests sampled only here):
  - left&right both high: ignored, remain READY.
  - left only: target = (pos_x < X_MIN+STEP) ? X_MIN : pos_x-STEP.
  - right only: target = (pos_x > X_MAX-STEP) ? X_MAX : pos_x+STEP.
  - Arithmetic is 9-bit internal, with no wrap.
  - target==pos_x: pulse blocked, no plots, remain READY.
  - Otherwise latch target and go to ERASE.
- ERASE:
  - Issue the sprite rectangle at the old pos_x with colour 0.
  - After the last issue, pos_x <= target, -> DRAW.
- A request held high repeats one move per completed DRAW.
- Requests in any state other than READY are ignored and not queued.

## Timing
- Issue stage (cycle t): counters plus rom_addr.
- Output stage (cycle t+1): x, y, colour, plot are registered; ROM data is consumed at this stage.
- Plot latency is exactly 1 cycle after issue. The stream has no gaps across CLEAR->DRAW and ERASE->DRAW.
- Cycle counts:
  - CLEAR: 19200 consecutive plots by default.
  - DRAW and ERASE: 110 plots each.
- done is asserted in the same cycle as the final DRAW plot, after both the initial draw and every move.
- READY is entered the cycle after the final DRAW issue. A request present then starts ERASE issue the following cycle.
- Reset values: state IDLE, pos_x=X_START, x=0, y=0, colour=0, plot=0, rom_addr=0, busy=0, done=0, blocked=0.
- Reset mid-operation (any state) takes effect on the next edge. It discards the in-flight output stage (plot=0), restores pos_x=X_START and drops the latched target.
- start is ignored outside IDLE.

## Test plan
- Reset then start pulse -> 19200 plots of colour 0, (0,0)..(159,119) raster. Then 110 plots x 73..83, y 105..114, colour = ROM[0..109]. Then done pulse, busy=0, pos_x=73.
- ROM pipeline check: ROM content = address mod 8 -> each plotted colour equals ((y-105)*11+(x-73)) mod 8. No off-by-one at row ends.
- left pulse in READY -> 110 colour-0 plots at x 73..83, then 110 ROM plots at x 68..78, pos_x=68, done.
- Clamping: 14 lefts from 73 -> pos_x=3; next left -> 0; next left -> blocked pulse, zero plots. Symmetric on the right: 148 -> 149, then blocked.
- left and right high together in READY for 20 cycles -> no plot, no blocked, pos_x unchanged. left held high -> back-to-back moves, one per done.
- Reset asserted mid-DRAW, after a move to pos_x=68 -> plot=0 the next cycle, state IDLE, pos_x=73. A fresh start redraws at 73.
